// File: rtl/led_scan_driver.sv
// 4x4 LED matrix scan driver: serial frame capture, double buffer, row scan.
// Optional anti-ghost blanking at the start of each row: `define LED_SCAN_BLANK_EN.
module led_scan_driver #(
   parameter int unsigned SCAN_DIV     = 250,
   parameter int unsigned BLANK_CYCLES = 8
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic bit_valid_in,
   input  logic data_in,
   input  logic frame_sync_in,
   output logic data_x1,
   output logic data_x2,
   output logic data_x3,
   output logic data_x4,
   output logic data_y1,
   output logic data_y2,
   output logic data_y3,
   output logic data_y4,
   output logic frame_done_out
);

   // Counter wide enough for both the row period and the blank window.
   localparam int unsigned LP_CNT_MAX =
      (BLANK_CYCLES > SCAN_DIV) ? BLANK_CYCLES : SCAN_DIV;
   localparam int unsigned CW =
      (LP_CNT_MAX > 2) ? $clog2(LP_CNT_MAX) : 1;

   typedef enum logic [1:0] {
      ROW0,
      ROW1,
      ROW2,
      ROW3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_row_cnt;
   logic          w_row_end;
   logic          w_commit;
   logic          w_blank;

   logic [15:0]   r_shadow;
   logic [15:0]   w_shadow_nxt;
   logic [15:0]   r_pending;
   logic [15:0]   r_display;
   logic          r_pend_flag;
   logic [3:0]    r_bit_cnt;
   logic [3:0]    w_idx;
   logic          w_last;
   logic          r_frame_done;

   logic [3:0]    r_x;
   logic [3:0]    r_y;
   logic [3:0]    w_x_nxt;
   logic [3:0]    w_y_nxt;

   assign w_row_end = (r_row_cnt == CW'(SCAN_DIV - 1));
   assign w_commit  = w_row_end && (r_state == ROW3);

`ifdef LED_SCAN_BLANK_EN
   assign w_blank = (r_row_cnt < CW'(BLANK_CYCLES));
`else
   assign w_blank = 1'b0;
`endif

   // Sync overrides the bit position, so a synced bit always lands at 0.
   assign w_idx  = frame_sync_in ? 4'd0 : r_bit_cnt;
   assign w_last = bit_valid_in && (w_idx == 4'd15);

   always_comb begin
      w_shadow_nxt        = r_shadow;
      w_shadow_nxt[w_idx] = data_in;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_shadow     <= '0;
         r_bit_cnt    <= '0;
         r_pending    <= '0;
         r_pend_flag  <= 1'b0;
         r_display    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_last;
         if (bit_valid_in) begin
            r_shadow  <= w_shadow_nxt;
            r_bit_cnt <= w_idx + 4'd1;
         end else if (frame_sync_in) begin
            r_bit_cnt <= '0;
         end
         if (w_commit && r_pend_flag) begin
            r_display <= r_pending;
         end
         // A frame landing on the commit edge wins the flag for next cycle.
         if (w_last) begin
            r_pending   <= w_shadow_nxt;
            r_pend_flag <= 1'b1;
         end else if (w_commit) begin
            r_pend_flag <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state   <= ROW0;
         r_row_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_row_end) begin
            r_row_cnt <= '0;
         end else begin
            r_row_cnt <= r_row_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_y_nxt     = 4'hF;
      w_x_nxt     = 4'h0;
      unique case (r_state)
         ROW0: begin
            w_y_nxt = 4'b1110;
            w_x_nxt = r_display[3:0];
            if (w_row_end) w_state_nxt = ROW1;
         end
         ROW1: begin
            w_y_nxt = 4'b1101;
            w_x_nxt = r_display[7:4];
            if (w_row_end) w_state_nxt = ROW2;
         end
         ROW2: begin
            w_y_nxt = 4'b1011;
            w_x_nxt = r_display[11:8];
            if (w_row_end) w_state_nxt = ROW3;
         end
         ROW3: begin
            w_y_nxt = 4'b0111;
            w_x_nxt = r_display[15:12];
            if (w_row_end) w_state_nxt = ROW0;
         end
         default: begin
            w_state_nxt = ROW0;
         end
      endcase
      if (w_blank) begin
         w_y_nxt = 4'hF;
         w_x_nxt = 4'h0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_x <= 4'h0;
         r_y <= 4'hF;
      end else begin
         r_x <= w_x_nxt;
         r_y <= w_y_nxt;
      end
   end

   assign data_x1        = r_x[0];
   assign data_x2        = r_x[1];
   assign data_x3        = r_x[2];
   assign data_x4        = r_x[3];
   assign data_y1        = r_y[0];
   assign data_y2        = r_y[1];
   assign data_y3        = r_y[2];
   assign data_y4        = r_y[3];
   assign frame_done_out = r_frame_done;

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver: directed frames plus random strobes,
// checked every cycle against a time-indexed reference model.
module tb_led_scan_driver;

   localparam int SD = 20;
   localparam int BL = 4;
`ifdef LED_SCAN_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic clk_in = 1'b0;
   logic rst_n_in;
   logic bit_valid_in;
   logic data_in;
   logic frame_sync_in;
   logic data_x1, data_x2, data_x3, data_x4;
   logic data_y1, data_y2, data_y3, data_y4;
   logic frame_done_out;

   int checks = 0;
   int fails  = 0;

   // Reference model state
   int          e;
   logic [15:0] m_shadow;
   logic [15:0] m_pend;
   logic [15:0] m_disp;
   bit          m_flag;
   int          m_bcnt;

   led_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .bit_valid_in(bit_valid_in),
      .data_in(data_in),
      .frame_sync_in(frame_sync_in),
      .data_x1(data_x1),
      .data_x2(data_x2),
      .data_x3(data_x3),
      .data_x4(data_x4),
      .data_y1(data_y1),
      .data_y2(data_y2),
      .data_y3(data_y3),
      .data_y4(data_y4),
      .frame_done_out(frame_done_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [8:0] obs();
      return {frame_done_out, data_y4, data_y3, data_y2, data_y1,
              data_x4, data_x3, data_x2, data_x1};
   endfunction

   task automatic check(input string tag, input logic [8:0] o,
                        input logic [8:0] x);
      checks++;
      assert (o === x) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, e, o, x);
      end
   endtask

   task automatic model_reset();
      e        = 0;
      m_shadow = '0;
      m_pend   = '0;
      m_disp   = '0;
      m_flag   = 1'b0;
      m_bcnt   = 0;
   endtask

   // One clock: drive inputs, predict, sample 1 time unit after the edge.
   task automatic cyc(input string tag, input logic v, input logic d,
                      input logic s);
      int row, cnt, idx;
      bit lit;
      logic [3:0] ey, ex;
      logic ed;
      bit_valid_in  = v;
      data_in       = d;
      frame_sync_in = s;
      e++;
      row = ((e - 1) / SD) % 4;
      cnt = (e - 1) % SD;
      lit = !(BLANK && cnt < BL);
      ey  = 4'hF;
      ex  = 4'h0;
      if (lit) begin
         ey[row] = 1'b0;
         ex      = m_disp[4*row +: 4];
      end
      ed = 1'b0;
      if ((e % (4 * SD)) == 0 && m_flag) begin
         m_disp = m_pend;
         m_flag = 1'b0;
      end
      if (v) begin
         idx = s ? 0 : m_bcnt;
         m_shadow[idx] = d;
         m_bcnt = (idx + 1) % 16;
         if (idx == 15) begin
            m_pend = m_shadow;
            m_flag = 1'b1;
            ed     = 1'b1;
         end
      end else if (s) begin
         m_bcnt = 0;
      end
      @(posedge clk_in);
      #1;
      check(tag, obs(), {ed, ey, ex});
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic wait_phase(input string tag, input int p);
      while ((e % (4 * SD)) != p) cyc(tag, 1'b0, 1'b0, 1'b0);
   endtask

   // Words go out MSB first, so word bit 15 becomes frame bit 0.
   task automatic send_word(input string tag, input logic [15:0] w,
                            input int gap);
      for (int i = 0; i < 16; i++) begin
         if (gap > 0) idle(tag, $urandom_range(0, gap));
         cyc(tag, 1'b1, w[15-i], 1'b0);
      end
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst_n_in      = 1'b0;
      bit_valid_in  = 1'b0;
      frame_sync_in = 1'b0;
      #1;
      check({tag, "_assert"}, obs(), 9'b0_1111_0000);
      @(posedge clk_in);
      #1;
      check({tag, "_hold"}, obs(), 9'b0_1111_0000);
      rst_n_in = 1'b1;
      model_reset();
      #1;
      check({tag, "_release"}, obs(), 9'b0_1111_0000);
   endtask

   initial begin
      rst_n_in      = 1'b0;
      bit_valid_in  = 1'b0;
      data_in       = 1'b0;
      frame_sync_in = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_hold", obs(), 9'b0_1111_0000);
      rst_n_in = 1'b1;
      #1;
      check("rst_release", obs(), 9'b0_1111_0000);
      idle("rst_dark", 4 * SD);

      send_word("f8421", 16'h8421, 0);
      idle("f8421_show", 8 * SD);

      wait_phase("ff00_align", 1);
      send_word("ff00_a", 16'hFFFF, 0);
      send_word("ff00_b", 16'h0000, 0);
      idle("ff00_show", 8 * SD);

      for (int i = 0; i < 7; i++)
         cyc("sync_part", 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      cyc("sync_only", 1'b0, 1'b0, 1'b1);
      send_word("sync_f000", 16'hF000, 0);
      idle("sync_show", 8 * SD);

      for (int i = 0; i < 5; i++)
         cyc("syncv_part", 1'b1, 1'b1, 1'b0);
      cyc("syncv_first", 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++)
         cyc("syncv_rest", 1'b1, 1'(i % 2), 1'b0);
      idle("syncv_show", 8 * SD);

      send_word("rst_ffff", 16'hFFFF, 1);
      idle("rst_commit", 4 * SD);
      wait_phase("rst_row2", 2 * SD + 7);
      async_reset("mid_scan");
      idle("post_rst", 8 * SD);

      for (int i = 0; i < 1500; i++)
         cyc("random", 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
      for (int i = 0; i < 6; i++) begin
         send_word("rand_word", 16'($urandom), 3);
         idle("rand_gap", $urandom_range(0, 6 * SD));
      end
      idle("final", 8 * SD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Downstream stage of the LED frame sequencer. It consumes the serial one-bit-per-strobe pixel stream (16 bits per frame, bit 0 first), deserializes it into a 4x4 frame and drives the row/column lines of a multiplexed 4x4 LED matrix with time-multiplexed row scanning. A double buffer keeps the image tear-free: the visible frame changes only at a scan-cycle boundary.

## Interface

Parameters:
- SCAN_DIV, 250: clk_in cycles per row period; legal range 2..65535.
- BLANK_CYCLES, 8: blanking cycles at the start of each row period; must be < SCAN_DIV. Used only with LED_SCAN_BLANK_EN.

Ports:
- clk_in, input, 1: single system clock; all logic on its rising edge.
- rst_n_in, input, 1: reset, asynchronous assert, active-low.
- bit_valid_in, input, 1: one-cycle strobe; data_in is sampled when high.
- data_in, input, 1: pixel bit, 1 = LED on.
- frame_sync_in, input, 1: forces the next captured bit to be bit 0 of a new frame.
- data_x1..data_x4, output, 1 each: column drives, active-high, registered.
- data_y1..data_y4, output, 1 each: row selects, active-low, registered.
- frame_done_out, output, 1: one-cycle pulse when the 16th bit of a frame is captured.

## Operation

- Bit mapping: frame bit i (0..15) maps to row i/4 (0..3) and column i%4. Row r is driven on data_y(r+1); column c is driven on data_x(c+1).
- Capture: a 4-bit bit counter, reset to 0.
  - On bit_valid_in, data_in is written to shadow[bit_cnt] and bit_cnt increments, wrapping 15 -> 0.
  - When bit 15 is written: frame_done_out pulses on the next cycle, the shadow is copied into pending, and the pending flag is set.
- frame_sync_in without bit_valid_in clears bit_cnt to 0 and leaves shadow unchanged. With bit_valid_in in the same cycle, sync wins: the bit is written as bit 0 and bit_cnt becomes 1.
- Partial frames are never committed.
- Commit: at the end of the row-3 period, if pending is set, pending is copied to the display buffer and the flag is cleared.
  - A second completed frame arriving before commit overwrites pending (latest wins, no error).
  - A frame completing on the same cycle as a commit is held for the next scan cycle.
- Scan FSM, states ROW0, ROW1, ROW2, ROW3, cycling:
  - A row counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 the FSM advances to the next row (ROW3 -> ROW0) and the counter clears.
  - In state ROWr, data_y(r+1) = 0, the other rows = 1, and data_x = display[4r..4r+3].
- Reset, including mid-frame or mid-scan:
  - Cleared: all buffers, bit_cnt, the pending flag, the row counter; the FSM returns to ROW0.
  - Outputs: data_x* = 0, data_y* = 1 (matrix dark), frame_done_out = 0.

## Timing

- Outputs are registered; row and column changes appear one cycle after the FSM or counter edge and always switch on the same edge.
- Capture latency: bit 15 is sampled on edge N; frame_done_out is high during cycle N+1.
- Display latency: the first visible change occurs at the start of the next ROW0 after pending is set. Worst case is 4*SCAN_DIV + 1 cycles.
- Full scan period is 4*SCAN_DIV cycles; refresh rate = f(clk_in) / (4*SCAN_DIV).
- bit_valid_in may arrive on consecutive cycles; no back-pressure and no overflow condition exists.

## Configuration

- LED_SCAN_BLANK_EN defined: during row-counter values 0..BLANK_CYCLES-1 of every row period, all data_y* = 1 and all data_x* = 0 (anti-ghosting). Each row is lit for SCAN_DIV-BLANK_CYCLES cycles.
- Not defined: BLANK_CYCLES is ignored and each row is lit for the full SCAN_DIV cycles; the row select changes directly between adjacent rows on the same edge.

## Test plan

- Reset check: hold rst_n_in low, then release -> data_y1..4 = 1111, data_x1..4 = 0000, frame_done_out = 0; after 4*SCAN_DIV cycles the outputs are still dark.
- Single frame 0x8421, bits sent MSB first on 16 strobes -> frame_done_out pulses once, one cycle after the 16th strobe. After the next ROW0 start, each row r shows only column r lit, with data_y(r+1) low for SCAN_DIV cycles (no blank).
- Two frames, 0xFFFF then 0x0000, both completed before the row-3 period ends -> only 0x0000 is ever displayed, and 0xFFFF is never visible.
- frame_sync_in asserted after 7 bits, then 16 bits of 0xF000 -> displayed frame is 0xF000 (row 0 all on); frame_done_out pulses once.
- rst_n_in pulsed low mid-scan while row 2 is active with frame 0xFFFF -> outputs go dark asynchronously; after release the display stays 0x0000 until a new frame arrives.
- With LED_SCAN_BLANK_EN, SCAN_DIV = 20, BLANK_CYCLES = 4 -> each row period shows 4 dark cycles followed by 16 lit cycles; the period is 80 cycles.
